// File: rtl/vcii_seq_pkg.sv
// vcii_seq_pkg: state encoding, default sizing and timer width helper
// shared by the VCII sequencer files.
package vcii_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS_UP,
        CONNECT,
        MEASURE,
        RELEASE,
        BIAS_DN,
        DONE
    } state_t;

    localparam int DEF_SETTLE_CYC = 64;
    localparam int DEF_MEAS_CYC   = 256;
    localparam int DEF_CNT_W      = 16;

    // One timer serves every timed phase, so size it for the longest one.
    function automatic int timer_w(input int settle, input int meas);
        int longest;
        longest = (settle > meas) ? settle : meas;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/vcii_sync2.sv
// vcii_sync2: two-flop synchroniser for an asynchronous level input,
// asynchronous active-high reset to 0.
module vcii_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vcii_seq_ctrl.sv
// vcii_seq_ctrl: power-up / connect / measure / break-before-make release
// sequencer for the VCII macro. Option macro: VCII_SEQ_KEEP_BIAS_EN.
module vcii_seq_ctrl
    import vcii_seq_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int MEAS_CYC   = DEF_MEAS_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             bias_en,
    output logic             sw_x_en,
    output logic             sw_z_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] result
);

`ifdef VCII_SEQ_KEEP_BIAS_EN
    localparam bit KEEP_BIAS = 1'b1;
`else
    localparam bit KEEP_BIAS = 1'b0;
`endif

    localparam int TW = timer_w(SETTLE_CYC, MEAS_CYC);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] MEAS_LAST   = TW'(MEAS_CYC - 1);
    localparam logic [CNT_W-1:0] RESULT_MAX = '1;

    state_t            r_state;
    state_t            w_next;
    logic [TW-1:0]     r_timer;
    logic              r_bias_en;
    logic              r_sw_en;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [CNT_W-1:0]  r_result;
    logic              w_cmp_sync;
    logic              w_active;
    logic              w_accept;

    vcii_sync2 u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .i_d (cmp_in),
        .o_q (w_cmp_sync)
    );

    always_comb begin
        w_active = (r_state == BIAS_UP) || (r_state == CONNECT) ||
                   (r_state == MEASURE);
        w_next   = r_state;
        unique case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_next = (KEEP_BIAS && r_bias_en) ? CONNECT : BIAS_UP;
                end
            end
            BIAS_UP: begin
                if (abort) begin
                    w_next = RELEASE;
                end else if (r_timer == SETTLE_LAST) begin
                    w_next = CONNECT;
                end
            end
            CONNECT: begin
                if (abort) begin
                    w_next = RELEASE;
                end else if (r_timer == SETTLE_LAST) begin
                    w_next = MEASURE;
                end
            end
            MEASURE: begin
                if (abort || (r_timer == MEAS_LAST)) begin
                    w_next = RELEASE;
                end
            end
            // An aborted run always drops bias, even when bias is kept.
            RELEASE: w_next = (KEEP_BIAS && !r_aborted) ? DONE : BIAS_DN;
            BIAS_DN: w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_accept = (r_state == IDLE) && (w_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if ((w_next != r_state) || !w_active) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Outputs are decoded from the next state so they are plain flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bias_en <= 1'b0;
            r_sw_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == BIAS_UP) begin
                r_bias_en <= 1'b1;
            end else if (w_next == BIAS_DN) begin
                r_bias_en <= 1'b0;
            end
            r_sw_en <= (w_next == CONNECT) || (w_next == MEASURE);
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aborted <= 1'b0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_aborted <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_active && abort) begin
                r_aborted <= 1'b1;
            end
            if ((r_state == MEASURE) && w_cmp_sync &&
                (r_result != RESULT_MAX)) begin
                r_result <= r_result + CNT_W'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(r_sw_en && !r_bias_en));

    assign bias_en = r_bias_en;
    assign sw_x_en = r_sw_en;
    assign sw_z_en = r_sw_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign result  = r_result;

endmodule

// File: tb/tb_vcii_seq_ctrl.sv
// tb_vcii_seq_ctrl: randomized bench for vcii_seq_ctrl; the reference
// derives each run's phase schedule and count from its own arithmetic.
module tb_vcii_seq_ctrl;

    localparam int S  = 4;
    localparam int M  = 8;
    localparam int W  = 4;
    localparam int M2 = 20;

`ifdef VCII_SEQ_KEEP_BIAS_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         cmp_in;
    logic         bias_en;
    logic         sw_x_en;
    logic         sw_z_en;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] result;

    logic         start_2;
    logic         abort_2;
    logic         cmp_2;
    logic         bias_en_2;
    logic         sw_x_2;
    logic         sw_z_2;
    logic         busy_2;
    logic         done_2;
    logic         aborted_2;
    logic [W-1:0] result_2;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_bias_on;
    bit m_aborted;
    int m_result;

    vcii_seq_ctrl #(.SETTLE_CYC(S), .MEAS_CYC(M), .CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .cmp_in  (cmp_in),
        .bias_en (bias_en),
        .sw_x_en (sw_x_en),
        .sw_z_en (sw_z_en),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .result  (result)
    );

    vcii_seq_ctrl #(.SETTLE_CYC(S), .MEAS_CYC(M2), .CNT_W(W)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .start   (start_2),
        .abort   (abort_2),
        .cmp_in  (cmp_2),
        .bias_en (bias_en_2),
        .sw_x_en (sw_x_2),
        .sw_z_en (sw_z_2),
        .busy    (busy_2),
        .done    (done_2),
        .aborted (aborted_2),
        .result  (result_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {busy, done, bias_en, sw_x_en, sw_z_en, aborted};
    endfunction

    function automatic int lead();
        return (KEEP && m_bias_on) ? 0 : S;
    endfunction

    // t=0 is the cycle start is presented; t=1 is the first busy cycle.
    task automatic run(input int mode, input int abort_t, input int restart_t);
        int         b;
        int         last_act;
        int         r;
        int         t_done;
        int         exp_cnt;
        bit         ab;
        bit         bias_after;
        bit         sw;
        bit         c[0:127];
        logic [5:0] exp_o;
        b          = lead();
        ab         = (abort_t >= 1) && (abort_t <= b + S + M);
        last_act   = ab ? abort_t : b + S + M;
        r          = last_act + 1;
        bias_after = KEEP && !ab;
        t_done     = r + (bias_after ? 1 : 2);
        for (int i = 0; i < 128; i++) begin
            case (mode)
                0:       c[i] = 1'b1;
                1:       c[i] = i[0];
                default: c[i] = 1'($urandom_range(0, 1));
            endcase
        end
        exp_cnt = 0;
        for (int t = b + S + 1; t <= last_act; t++) begin
            exp_cnt += int'(c[t-2]);
        end
        if (exp_cnt > (1 << W) - 1) exp_cnt = (1 << W) - 1;
        for (int t = 0; t <= t_done + 1; t++) begin
            sw = (t >= b + 1) && (t <= last_act);
            if (t == 0) begin
                exp_o = {2'b00, m_bias_on, 2'b00, m_aborted};
            end else begin
                exp_o = {t <= t_done, t == t_done,
                         (t <= r) ? 1'b1 : bias_after,
                         sw, sw, ab && (t >= r)};
            end
            check($sformatf("out_t%0d", t), 32'(outs()), 32'(exp_o));
            check("inv", 32'((sw_x_en | sw_z_en) & ~bias_en), 0);
            if (t == 1) check("res_clr", 32'(result), 0);
            if (t >= t_done) check($sformatf("result_t%0d", t),
                                   32'(result), exp_cnt);
            start  = (t == 0) || ((t == restart_t) && (t < t_done));
            abort  = ab && (t >= abort_t) && (t <= t_done);
            cmp_in = c[t];
            if (t <= t_done) cyc();
        end
        m_bias_on = bias_after;
        m_aborted = ab;
        m_result  = exp_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int b;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        cmp_in  = 1'b0;
        start_2 = 1'b0;
        abort_2 = 1'b0;
        cmp_2   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'({outs(), result}), 0);
        check("rst_outs2", 32'({busy_2, done_2, bias_en_2, sw_x_2, sw_z_2,
                                aborted_2, result_2}), 0);
        rst = 1'b0;
        cyc();
        m_bias_on = 1'b0;
        m_aborted = 1'b0;
        m_result  = 0;
        check("idle", 32'({outs(), result}), 0);

        run(0, 0, 0);
        run(1, 0, 0);
        run(0, lead() + S + 3, 0);
        run(0, 0, 0);

        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_block", 32'(outs()),
                  32'({2'b00, m_bias_on, 2'b00, m_aborted}));
            check("idle_res", 32'(result), m_result);
            cyc();
        end

        run(2, 0, 3);
        run(2, 0, 9);
        for (int k = 0; k < 8; k++) begin
            run(2,
                ($urandom_range(0, 1) == 1) ?
                    int'($urandom_range(1, lead() + S + M)) : 0,
                ($urandom_range(0, 1) == 1) ?
                    int'($urandom_range(1, 20)) : 0);
        end

        start_2 = 1'b1;
        cyc();
        start_2 = 1'b0;
        n = 1;
        while (!done_2 && n < 100) begin
            cyc();
            n++;
        end
        check("sat_lat", n, 2 * S + M2 + 3);
        check("sat_res", 32'(result_2), (1 << W) - 1);
        cyc();

        b      = lead();
        start  = 1'b1;
        cmp_in = 1'b1;
        cyc();
        start = 1'b0;
        repeat (b + S + 1) cyc();
        check("pre_rst_sw", 32'({busy, sw_x_en, sw_z_en}), 32'h7);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 32'({outs(), result}), 0);
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst", 32'({outs(), result}), 0);
        m_bias_on = 1'b0;
        m_aborted = 1'b0;
        m_result  = 0;
        run(0, 0, 0);
        run(1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vcii_seq_ctrl.md
# vcii_seq_ctrl

Digital sequencer for the VCII analog macro. Powers up the bias, closes the analog switches onto the X and Z pins, measures the externally comparated Z response over a fixed window, then releases the macro in break-before-make order. Sits beside the VCII in the tile wrapper. Driven by `ui_in` control bits; results are returned on `uo_out`/`uio_out`.

## Interface
Parameters:
- `SETTLE_CYC`, 64: cycles waited after bias enable, and again after switch closure (≥2).
- `MEAS_CYC`, 256: length of the measurement window in cycles (≥1).
- `CNT_W`, 16: width of the result counter.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level, sampled in IDLE; begins a sequence.
- `abort` in 1: level; forces the release path from any active state.
- `cmp_in` in 1: asynchronous comparator output on Z; synchronised internally.
- `bias_en` out 1: enables the VCII bias/supply switch.
- `sw_x_en` out 1: closes the stimulus-to-X switch.
- `sw_z_en` out 1: closes the Z-to-load switch.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at sequence end.
- `aborted` out 1: sticky; set on abort; cleared on next accepted start.
- `result` out CNT_W: count of cycles the synchronised comparator was high during MEASURE.

## Operation
- Reset: every output is 0, `result`=0, state IDLE, counters 0.
- States:
  - IDLE → BIAS_UP on `start`=1 and `abort`=0. Accepting `start` clears `result` and `aborted`.
  - BIAS_UP: `bias_en`=1; wait SETTLE_CYC cycles → CONNECT.
  - CONNECT: `sw_x_en`=`sw_z_en`=1; wait SETTLE_CYC cycles → MEASURE.
  - MEASURE: switches stay closed. Each cycle, `result` increments if synced cmp=1. After MEAS_CYC cycles → RELEASE.
  - RELEASE: both switches open on entry; `bias_en` is held for exactly 1 further cycle → BIAS_DN.
  - BIAS_DN: `bias_en`=0 → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `abort`=1 in BIAS_UP, CONNECT or MEASURE: next state is RELEASE, `aborted` is set, and `result` is frozen at its partial value. In RELEASE, BIAS_DN or DONE, `abort` is ignored. In IDLE, `abort` blocks `start`.
- `start` is ignored while `busy`=1. No queuing.
- `result` saturates at 2^CNT_W−1. It never wraps.
- Switch outputs are never high while `bias_en`=0. This is a checked invariant.
- `cmp_in` passes through a 2-flop synchroniser. The sample counted on MEASURE cycle k reflects `cmp_in` at cycle k−2.

## Timing
- Outputs are registered from state; no combinational input-to-output paths.
- `start` to `bias_en` high: 1 cycle.
- Full sequence from start acceptance to the `done` pulse: 2·SETTLE_CYC + MEAS_CYC + 3 cycles.
- Abort to switches open: 1 cycle. Abort to `bias_en` low: 2 cycles.
- `result` is stable from the `done` cycle until the next accepted start.
- Reset asserted mid-sequence clears all outputs asynchronously, without break-before-make. The analog side tolerates this.

## Configuration
- `VCII_SEQ_KEEP_BIAS_EN` defined:
  - RELEASE goes to DONE and skips BIAS_DN, so `bias_en` stays 1 after the sequence.
  - The next start from IDLE with bias already on skips BIAS_UP and goes directly to CONNECT. Start to `done` is then SETTLE_CYC + MEAS_CYC + 2 cycles.
  - `abort` still drops bias via BIAS_DN.
  - Reset clears bias.
- Not defined: bias is always cycled as described in Operation.

## Structure
- Package `vcii_seq_pkg` holds:
  - State enum: IDLE, BIAS_UP, CONNECT, MEASURE, RELEASE, BIAS_DN, DONE.
  - Default constants: SETTLE_CYC, MEAS_CYC, CNT_W.
  - A shared phase-timer width function: clog2 of max(SETTLE_CYC, MEAS_CYC)+1.
- Sub-module `vcii_sync2`: 2-flop synchroniser with async active-high reset to 0. Instantiated once for `cmp_in`.

## Test plan
All scenarios use SETTLE_CYC=4, MEAS_CYC=8, CNT_W=4 unless a different value is stated.
- Reset then `start` pulse with `cmp_in` held 1 → `done` at cycle 19 after acceptance, `result`=8, `aborted`=0.
- `cmp_in` toggling every cycle → `result`=4. Also check the bias/switch edge order: switches fall one cycle before `bias_en`.
- `abort` on MEASURE cycle 3 with `cmp_in`=1 → switches low next cycle, `bias_en` low a cycle later, `done` pulses, `result`=3 (synchroniser-adjusted), `aborted`=1.
- MEAS_CYC=20 with CNT_W=4 and `cmp_in`=1 → `result` saturates at 15.
- `start` re-pulsed while busy, and `start`+`abort` asserted together in IDLE → no extra sequence, `busy` stays 0 in the IDLE case.
- With `VCII_SEQ_KEEP_BIAS_EN`: second run → `bias_en` stays high throughout, start-to-done is 14 cycles. Assert `rst` mid-MEASURE → all outputs 0 asynchronously.
